// File: rtl/ddr3_pixel_reader.sv
// Frame reader: fetches 256-bit words from DDR3 over Avalon-MM bursts into a
// small word FIFO, then unpacks them LSB-first into a valid/ready pixel stream.
module ddr3_pixel_reader #(
    parameter int          out_width     = 16,
    parameter int          burst_len     = 8,
    parameter int          num_pixels    = 2764800,
    parameter logic [31:0] start_address = 32'h36000000,
    parameter int          fifo_depth    = 32
) (
    input  logic                 ddr3_clk,
    input  logic                 ddr3_clk_reset_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 frame_done,
    output logic [26:0]          ddr3_read_address,
    output logic                 ddr3_read,
    output logic [7:0]           ddr3_burstcount,
    input  logic                 ddr3_waitrequest,
    input  logic [255:0]         ddr3_readdata,
    input  logic                 ddr3_readdatavalid,
    output logic [out_width-1:0] pixel,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    output logic [7:0]           fifo_level,
    output logic                 rd_error
);

    localparam int PPW        = 256 / out_width;
    localparam int NUM_WORDS  = num_pixels / PPW;
    localparam int NUM_BURSTS = NUM_WORDS / burst_len;
    localparam int IDX_W      = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int AW         = $clog2(fifo_depth);
    localparam int BEAT_W     = $clog2(burst_len);
    localparam int BURST_W    = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

    localparam logic [AW:0]         DEPTH_C    = (AW+1)'(fifo_depth);
    localparam logic [AW:0]         BURST_C    = (AW+1)'(burst_len);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(PPW - 1);
    localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(burst_len - 1);
    localparam logic [BEAT_W-1:0]   BEAT_ONE   = BEAT_W'(1);
    localparam logic [BURST_W-1:0]  LAST_BURST = BURST_W'(NUM_BURSTS - 1);
    localparam logic [26:0]         START_WORD = start_address[31:5];
    localparam logic [26:0]         ADDR_STEP  = 27'(burst_len);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_REQ,
        ST_RX,
        ST_DRAIN
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [26:0]          r_addr;
    logic [BEAT_W-1:0]    r_beat;
    logic [BURST_W-1:0]   r_burst;
    logic                 r_err;

    logic [255:0]         r_mem [fifo_depth];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [AW:0]          r_count;

    logic [255:0]         r_word;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_valid;

    logic w_full;
    logic w_empty;
    logic w_space_ok;
    logic w_accept;
    logic w_last_px;
    logic w_pop;
    logic w_req_acc;
    logic w_beat;
    logic w_push;
    logic w_last_beat;
    logic w_last_burst;
    logic w_frame_end;

    assign w_full       = (r_count == DEPTH_C);
    assign w_empty      = (r_count == '0);
    assign w_space_ok   = ((DEPTH_C - r_count) >= BURST_C);
    assign w_accept     = r_valid & pixel_ready;
    assign w_last_px    = (r_idx == LAST_IDX);
    assign w_pop        = !w_empty & (!r_valid | (w_accept & w_last_px));
    assign w_req_acc    = (r_state == ST_REQ) & !ddr3_waitrequest;
    // A beat may land in the very cycle the request is accepted.
    assign w_beat       = ddr3_readdatavalid & ((r_state == ST_RX) | w_req_acc);
    assign w_push       = w_beat & !w_full;
    assign w_last_beat  = w_beat & (r_state == ST_RX) & (r_beat == LAST_BEAT);
    assign w_last_burst = (r_burst == LAST_BURST);
    assign w_frame_end  = (r_state == ST_DRAIN) & w_empty & w_accept & w_last_px;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default first in always_comb so no path leaves a variable unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (start)             w_state_next = ST_CHECK;
            ST_CHECK: if (w_space_ok)        w_state_next = ST_REQ;
            ST_REQ:   if (!ddr3_waitrequest) w_state_next = ST_RX;
            ST_RX:    if (w_last_beat)       w_state_next = w_last_burst ? ST_DRAIN : ST_CHECK;
            ST_DRAIN: if (w_frame_end)       w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = 1'b1;
        ddr3_read  = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            ST_IDLE:  busy       = 1'b0;
            ST_REQ:   ddr3_read  = 1'b1;
            ST_DRAIN: frame_done = w_frame_end;
            default:  ;
        endcase
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            r_addr  <= '0;
            r_beat  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && start) begin
                r_addr  <= START_WORD;
                r_burst <= '0;
            end
            if (w_req_acc) begin
                r_beat <= ddr3_readdatavalid ? BEAT_ONE : '0;
            end else if (w_beat) begin
                r_beat <= r_beat + BEAT_ONE;
            end
            if (w_last_beat && !w_last_burst) begin
                r_addr  <= r_addr + ADDR_STEP;
                r_burst <= r_burst + 1'b1;
            end
            if (ddr3_readdatavalid && (!w_beat || w_full)) begin
                r_err <= 1'b1;
            end
        end
    end

    // NOTE: FIFO storage is left unreset; pointers and count alone define what is valid.
    always_ff @(posedge ddr3_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ddr3_readdata;
        end
    end

    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The unpacker word doubles as the registered FIFO read port, so a reload
    // on the last pixel's accept costs no bubble.
    always_ff @(posedge ddr3_clk or negedge ddr3_clk_reset_n) begin
        if (!ddr3_clk_reset_n) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else if (w_pop) begin
            r_word  <= r_mem[r_rd_ptr];
            r_idx   <= '0;
            r_valid <= 1'b1;
        end else if (w_accept) begin
            r_word  <= r_word >> out_width;
            r_idx   <= r_idx + 1'b1;
            r_valid <= !w_last_px;
        end
    end

    assign ddr3_read_address = r_addr;
    assign ddr3_burstcount   = 8'(burst_len);
    assign pixel             = r_word[out_width-1:0];
    assign pixel_valid       = r_valid;
    assign fifo_level        = 8'(r_count);
    assign rd_error          = r_err;

endmodule
